// File: rtl/addsub_serial.sv
// addsub_serial -- digit-serial two's-complement adder/subtractor.
//
// Operands arrive over a valid/ready handshake and are processed SLICE bits
// per clock, LSB slice first. The result is returned with carry, signed
// overflow, zero and negative flags over a second valid/ready handshake.
//
// Optional feature (compile-time macro):
//   ADDSUB_SATURATE_EN  - clamp the result on signed overflow instead of
//                         wrapping modulo 2^WIDTH. Undefined by default.
//
// Parameters:
//   WIDTH - operand/result width; must be a multiple of SLICE.
//   SLICE - bits processed per clock, 1 <= SLICE <= WIDTH.

module addsub_serial #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    // Saturation bounds (most positive / most negative WIDTH-bit values).
    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // ------------------------------------------------------------------
    // FSM state
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // in_ready is registered so that it reads 0 during reset and rises on
    // the first clock edge after rst_n is released.
    logic ready_q, ready_d;

    // Handshake / sequencing strobes decoded by the FSM.
    logic accept;
    logic last_slice;

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             c_q, c_d;          // running inter-slice carry

    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;

    // ------------------------------------------------------------------
    // Slice arithmetic signals
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] idx;               // bit offset of the current slice
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] bx_sl;             // b slice, inverted for subtraction
    logic [SLICE:0]   slice_sum;
    logic             c_out;
    logic             c_into_msb;
    logic             ovf_now;
    logic [WIDTH-1:0] res_wrapped;       // result register with slice merged
    logic [WIDTH-1:0] res_final;         // wrapped or clamped final value

    // ------------------------------------------------------------------
    // FSM next-state and handshake decode
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        last_slice = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid && ready_q) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (cnt_q == LAST_CNT) begin
                    last_slice = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    // FSM state register and registered in_ready.
    // NOTE: sequential state is written with non-blocking assignments so
    // every register samples its pre-edge inputs, independent of order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // ------------------------------------------------------------------
    // One slice of the add/subtract, plus the final-value selection.
    // ------------------------------------------------------------------
    // Compute the current slice sum, carry into/out of the MSB and the
    // final (optionally clamped) result.
    always_comb begin
        idx   = IDX_W'(int'(cnt_q) * SLICE);
        a_sl  = a_q[idx +: SLICE];
        bx_sl = b_q[idx +: SLICE] ^ {SLICE{sub_q}};

        slice_sum = {1'b0, a_sl} + {1'b0, bx_sl} + (SLICE + 1)'(c_q);
        c_out     = slice_sum[SLICE];

        // Sum bit = a ^ b ^ cin, so the carry into the slice MSB is
        // recovered without a separate narrower adder (works for SLICE=1).
        c_into_msb = a_sl[SLICE-1] ^ bx_sl[SLICE-1] ^ slice_sum[SLICE-1];
        ovf_now    = c_into_msb ^ c_out;

        res_wrapped                = res_q;
        res_wrapped[idx +: SLICE]  = slice_sum[SLICE-1:0];

        res_final = res_wrapped;
`ifdef ADDSUB_SATURATE_EN
        // A wrapped MSB of 1 on overflow means the true result was
        // positive (and vice versa), so clamp towards that sign.
        if (ovf_now) begin
            res_final = res_wrapped[WIDTH-1] ? SAT_POS : SAT_NEG;
        end
`endif
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    // Load operands on accept, step one slice per RUN cycle, and capture
    // the flags together with the final slice.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        neg_d   = neg_q;

        if (accept) begin
            a_d   = a;
            b_d   = b;
            sub_d = sub;
            c_d   = sub;          // +1 of the two's-complement negation
            cnt_d = '0;
        end else if (state_q == RUN) begin
            c_d = c_out;
            if (last_slice) begin
                res_d   = res_final;
                carry_d = c_out;
                ovf_d   = ovf_now;
                zero_d  = (res_final == '0);
                neg_d   = res_final[WIDTH-1];
            end else begin
                res_d = res_wrapped;
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Datapath registers.
    // NOTE: operand and result registers are reset as well, because the
    // result and flags are visible outputs that must read 0 under reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = ready_q;
    assign out_valid = (state_q == DONE);
    assign result    = res_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;

endmodule
